// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: multi-word instruction fetch sequencer with MFC timeout and completion pulse
module if_fetch_ctrl #(
  parameter int WORDS   = 2,
  parameter int TIMEOUT = 16,
  parameter int WSEL_W  = 3,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic              MFC,
  output logic              PC_Out,
  output logic              MAR_EN,
  output logic              mem_EN,
  output logic              mem_RW,
  output logic              MDR_EN_read,
  output logic              MDR_out,
  output logic              IR_EN,
  output logic [WSEL_W-1:0] IR_word_sel,
  output logic              PC_inc,
  output logic              busy,
  output logic              fetch_valid,
  output logic              fetch_err
);
  typedef enum logic [3:0] {IDLE, ADDR, LATCH, REQ, WAIT, CAPTURE, XFER, LOAD, DONE, ERR} state_t;
  localparam logic [WSEL_W-1:0] LAST    = WSEL_W'(WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state_q, state_d;
  logic [WSEL_W-1:0] idx_q, idx_d, sel_q, sel_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [10:0] out_q, out_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE, ERR: if (start) begin state_d = ADDR; idx_d = '0; end
      ADDR: state_d = LATCH;
      LATCH: state_d = REQ;
      REQ: begin state_d = WAIT; cnt_d = '0; end
      WAIT:
        if (MFC) state_d = CAPTURE;
        else if (TIMEOUT != 0 && cnt_q == TO_LAST) state_d = ERR;
        else cnt_d = cnt_q + 1'b1;
      CAPTURE: state_d = XFER;
      XFER: state_d = LOAD;
      LOAD:
        if (idx_q == LAST) state_d = DONE;
        else begin state_d = ADDR; idx_d = idx_q + 1'b1; end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      idx_d = '0;
      cnt_d = '0;
    end
    out_d = {state_d inside {ADDR, LATCH}, state_d == LATCH, state_d inside {REQ, WAIT, CAPTURE},
             state_d inside {WAIT, CAPTURE, XFER, LOAD}, state_d == CAPTURE, state_d inside {XFER, LOAD},
             state_d == LOAD, state_d == LOAD, !(state_d inside {IDLE, ERR}), state_d == DONE, state_d == ERR};
    sel_d = state_d inside {IDLE, DONE, ERR} ? '0 : idx_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end
  assign {PC_Out, MAR_EN, mem_EN, mem_RW, MDR_EN_read, MDR_out, IR_EN, PC_inc, busy, fetch_valid, fetch_err} = out_q;
  assign IR_word_sel = sel_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: trace-model random and directed checks of two fetch controller configurations
module tb_if_fetch_ctrl;
  typedef enum {P_I, P_A, P_L, P_R, P_W, P_C, P_X, P_LD, P_D, P_E} ph_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic st [2], dn [2], mf [2], rs [2];
  logic [10:0] o [2];
  logic [2:0] s [2];
  int errs = 0, checks = 0, n_step = 0, ab_at = -1, pinc = 0, bcnt = 0;
  bit hit = 0, ab_rst = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pc, mar, me, rw, mdr_en, mdr_o, ir, inc, bsy, fv, fe;
    logic [2:0] sel;
    if_fetch_ctrl #(.WORDS(g == 0 ? 2 : 3), .TIMEOUT(g == 0 ? 16 : 4), .WSEL_W(3), .TO_W(8)) u (
      .clk(clk), .rst(rs[g]), .start(st[g]), .done(dn[g]), .MFC(mf[g]),
      .PC_Out(pc), .MAR_EN(mar), .mem_EN(me), .mem_RW(rw), .MDR_EN_read(mdr_en), .MDR_out(mdr_o),
      .IR_EN(ir), .IR_word_sel(sel), .PC_inc(inc), .busy(bsy), .fetch_valid(fv), .fetch_err(fe)
    );
    assign o[g] = {pc, mar, me, rw, mdr_en, mdr_o, ir, inc, bsy, fv, fe};
    assign s[g] = sel;
  end
  function automatic logic [10:0] exp_o(input ph_t p);
    case (p)
      P_A: return 11'b100_0000_0100;
      P_L: return 11'b110_0000_0100;
      P_R: return 11'b001_0000_0100;
      P_W: return 11'b001_1000_0100;
      P_C: return 11'b001_1100_0100;
      P_X: return 11'b000_1010_0100;
      P_LD: return 11'b000_1011_1100;
      P_D: return 11'b000_0000_0110;
      P_E: return 11'b000_0000_0001;
      default: return 11'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int d, input ph_t p, input int sel);
    @(posedge clk);
    #1;
    chk($sformatf("dut%0d %s step%0d", d, p.name(), n_step), 32'({o[d], s[d]}), 32'({exp_o(p), 3'(sel)}));
    pinc += int'(o[d][3]);
    bcnt += int'(o[d][2]);
  endtask
  task automatic hold(input int d, input ph_t p);
    st[d] = 0;
    mf[d] = 1'($urandom);
    tick(d, p, 0);
  endtask
  task automatic adv(input int d, input int m, input ph_t p, input int sel);
    if (hit) return;
    st[d] = 1'($urandom);
    mf[d] = m < 0 ? 1'($urandom) : 1'(m);
    if (n_step == ab_at) begin
      if (ab_rst) rs[d] = 1;
      else dn[d] = 1;
      tick(d, P_I, 0);
      rs[d] = 0;
      dn[d] = 0;
      hit = 1;
    end else tick(d, p, sel);
    st[d] = 0;
    n_step++;
  endtask
  task automatic fetch(input int d, input int wt [8], input int abort_at, input bit abort_rst);
    int w, to, sum, loaded;
    bit err;
    w = d ? 3 : 2;
    to = d ? 4 : 16;
    sum = 0;
    loaded = 0;
    err = 0;
    hit = 0;
    n_step = 0;
    ab_at = abort_at;
    ab_rst = abort_rst;
    pinc = 0;
    bcnt = 0;
    st[d] = 1;
    mf[d] = 1'($urandom);
    tick(d, P_A, 0);
    st[d] = 0;
    for (int k = 0; k < w && !err && !hit; k++) begin
      adv(d, -1, P_L, k);
      adv(d, -1, P_R, k);
      adv(d, -1, P_W, k);
      for (int j = 0; !hit; j++) begin
        if (j == wt[k]) begin adv(d, 1, P_C, k); break; end
        if (j == to - 1) begin adv(d, 0, P_E, 0); err = 1; break; end
        adv(d, 0, P_W, k);
      end
      if (err) break;
      sum += wt[k];
      adv(d, -1, P_X, k);
      adv(d, -1, P_LD, k);
      if (!hit) loaded++;
      if (k == w - 1) adv(d, -1, P_D, 0);
      else adv(d, -1, P_A, k + 1);
    end
    if (hit) return;
    if (err) chk($sformatf("dut%0d pc_inc on err", d), pinc, loaded);
    else begin
      adv(d, -1, P_I, 0);
      chk($sformatf("dut%0d pc_inc total", d), pinc, w);
      chk($sformatf("dut%0d busy cycles", d), bcnt, 7 * w + 1 + sum);
    end
  endtask
  initial begin
    int wt [8];
    int d;
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; dn[i] = 0; mf[i] = 0; rs[i] = 1;
    end
    tick(0, P_I, 0);
    tick(1, P_I, 0);
    rs[0] = 0;
    rs[1] = 0;
    hold(0, P_I);
    hold(1, P_I);
    fetch(0, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    fetch(0, '{0, 5, 0, 0, 0, 0, 0, 0}, -1, 0);
    fetch(1, '{99, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    hold(1, P_E);
    fetch(1, '{3, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    fetch(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 12, 0);
    hold(0, P_I);
    fetch(0, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    fetch(0, '{3, 0, 0, 0, 0, 0, 0, 0}, 4, 1);
    hold(0, P_I);
    fetch(0, '{0, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    repeat (60) begin
      d = int'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++)
        wt[k] = d ? int'($urandom_range(0, 5)) : ($urandom_range(0, 7) == 0 ? 20 : int'($urandom_range(0, 6)));
      fetch(d, wt, $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 15)) : -1, 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
